// File: rtl/inst_decode_stage_if.sv
// Handshake bundle for inst_decode_stage: instruction offer, decoded-entry
// presentation, flush, and the illegal-instruction counter.
interface inst_decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic                out_is_r;
    logic                out_is_i;
    logic                out_is_lui;
    logic                out_is_auipc;
    logic                out_is_load;
    logic                out_is_store;
    logic                out_is_branch;
    logic                out_is_jal;
    logic                out_is_jalr;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [XLEN-1:0]     out_imm;
    logic [4:0]          out_rd;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic                out_illegal;
    logic [15:0]         illegal_cnt;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_is_r, out_is_i, out_is_lui,
               out_is_auipc, out_is_load, out_is_store, out_is_branch,
               out_is_jal, out_is_jalr, out_alu_op, out_imm, out_rd, out_rs1,
               out_rs2, out_illegal, illegal_cnt
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_is_r, out_is_i, out_is_lui,
               out_is_auipc, out_is_load, out_is_store, out_is_branch,
               out_is_jal, out_is_jalr, out_alu_op, out_imm, out_rd, out_rs1,
               out_rs2, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/inst_decode_stage.sv
// RV32 decode stage: combinational decode into a registered 2-entry skid buffer.
// Define DECODE_MEXT_EN to decode RV32M (funct7 0000001) instead of flagging it illegal.
module inst_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
) (
    input logic                clk,
    input logic                rst,
    inst_decode_stage_if.slave bus
);
    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_PASS = 5'b01010;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic                is_r;
        logic                is_i;
        logic                is_lui;
        logic                is_auipc;
        logic                is_load;
        logic                is_store;
        logic                is_branch;
        logic                is_jal;
        logic                is_jalr;
        logic [ALU_OP_W-1:0] alu_op;
        logic [XLEN-1:0]     imm;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic                illegal;
    } entry_t;

    entry_t             dec;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         op;
    logic signed [31:0] imm32;
    logic               bad;

    assign funct3 = bus.in_inst[14:12];
    assign funct7 = bus.in_inst[31:25];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec     = '0;
        op      = ALU_ADD;
        imm32   = '0;
        bad     = 1'b0;
        dec.pc  = bus.in_pc;
        dec.rd  = bus.in_inst[11:7];
        dec.rs1 = bus.in_inst[19:15];
        dec.rs2 = bus.in_inst[24:20];
        case (opcode_e'(bus.in_inst[6:0]))
            OP_R: begin
                dec.is_r = 1'b1;
                case (funct7)
                    7'b0000000: op = {2'b00, funct3};
                    7'b0100000: begin
                        if (funct3 == 3'b000)      op  = ALU_SUB;
                        else if (funct3 == 3'b101) op  = ALU_SRA;
                        else                       bad = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    7'b0000001: op = {2'b10, funct3};
`endif
                    default:    bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.is_i = 1'b1;
                imm32    = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                op       = {2'b00, funct3};
                // Shift-immediates reuse the upper imm bits as funct7.
                if (funct3 == 3'b001 && funct7 != 7'b0000000) bad = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      op  = ALU_SRA;
                    else if (funct7 != 7'b0000000) bad = 1'b1;
                end
            end
            OP_LUI: begin
                dec.is_lui = 1'b1;
                imm32      = {bus.in_inst[31:12], 12'b0};
                op         = ALU_PASS;
            end
            OP_AUIPC: begin
                dec.is_auipc = 1'b1;
                imm32        = {bus.in_inst[31:12], 12'b0};
            end
            OP_LOAD: begin
                dec.is_load = 1'b1;
                imm32       = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
            end
            OP_STORE: begin
                dec.is_store = 1'b1;
                imm32        = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
            end
            OP_BRANCH: begin
                dec.is_branch = 1'b1;
                imm32 = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                         bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
                case (funct3[2:1])
                    2'b00:   op  = ALU_SUB;
                    2'b10:   op  = ALU_SLT;
                    2'b11:   op  = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.is_jal = 1'b1;
                imm32 = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                         bus.in_inst[20], bus.in_inst[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.is_jalr = 1'b1;
                imm32       = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
            end
            default: bad = 1'b1;
        endcase
        dec.alu_op = ALU_OP_W'(op);
        dec.imm    = XLEN'(imm32);
        if (bad) begin
            {dec.is_r, dec.is_i, dec.is_lui, dec.is_auipc, dec.is_load,
             dec.is_store, dec.is_branch, dec.is_jal, dec.is_jalr} = '0;
            dec.alu_op  = '0;
            dec.imm     = '0;
            dec.illegal = 1'b1;
        end
    end

    entry_t      main_q;
    entry_t      skid_q;
    logic        main_valid;
    logic        skid_valid;
    logic [15:0] cnt_q;
    logic        accept;
    logic        handoff;

    assign accept  = bus.in_valid & bus.in_ready;
    assign handoff = main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: entry payloads are reset as well so every output reads zero after reset.
            main_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (handoff && main_q.illegal && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (bus.flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (handoff && skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept && (!main_valid || handoff)) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end else if (handoff) begin
                main_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = ~skid_valid;
    assign bus.out_valid     = main_valid;
    assign bus.out_pc        = main_q.pc;
    assign bus.out_is_r      = main_q.is_r;
    assign bus.out_is_i      = main_q.is_i;
    assign bus.out_is_lui    = main_q.is_lui;
    assign bus.out_is_auipc  = main_q.is_auipc;
    assign bus.out_is_load   = main_q.is_load;
    assign bus.out_is_store  = main_q.is_store;
    assign bus.out_is_branch = main_q.is_branch;
    assign bus.out_is_jal    = main_q.is_jal;
    assign bus.out_is_jalr   = main_q.is_jalr;
    assign bus.out_alu_op    = main_q.alu_op;
    assign bus.out_imm       = main_q.imm;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_rs1       = main_q.rs1;
    assign bus.out_rs2       = main_q.rs2;
    assign bus.out_illegal   = main_q.illegal;
    assign bus.illegal_cnt   = cnt_q;
endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed self-checking bench for inst_decode_stage (expectations follow DECODE_MEXT_EN).
module tb_inst_decode_stage;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    inst_decode_stage_if #(.XLEN(32), .ALU_OP_W(5)) bus ();

    inst_decode_stage #(.XLEN(32), .ALU_OP_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [8:0] cls;
    assign cls = {bus.out_is_r, bus.out_is_i, bus.out_is_lui, bus.out_is_auipc, bus.out_is_load,
                  bus.out_is_store, bus.out_is_branch, bus.out_is_jal, bus.out_is_jalr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.illegal_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", bus.illegal_cnt); end
        checks++; if ({cls, bus.out_alu_op, bus.out_imm, bus.out_pc, bus.out_illegal} !== '0) begin
            failures++; $display("FAIL reset_outputs got cls=%b alu=%b imm=%h pc=%h ill=%b want all 0",
                                 cls, bus.out_alu_op, bus.out_imm, bus.out_pc, bus.out_illegal);
        end
        rst = 1'b0;
    endtask

    // Accept one instruction, check the registered decode next cycle, then hand it off.
    task automatic decode_one(input string name, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [8:0] cls_exp, input logic [4:0] alu_exp,
                              input logic [31:0] imm_exp, input logic ill_exp, input logic chk_regs,
                              input logic [4:0] rd_exp, input logic [4:0] rs1_exp, input logic [4:0] rs2_exp);
        bus.in_valid  = 1'b1;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s valid got=%b want=1", name, bus.out_valid); end
        checks++; if (bus.out_pc !== pc) begin failures++; $display("FAIL %s pc got=%h want=%h", name, bus.out_pc, pc); end
        checks++; if (cls !== cls_exp) begin failures++; $display("FAIL %s class got=%b want=%b", name, cls, cls_exp); end
        checks++; if (bus.out_alu_op !== alu_exp) begin failures++; $display("FAIL %s alu_op got=%b want=%b", name, bus.out_alu_op, alu_exp); end
        checks++; if (bus.out_imm !== imm_exp) begin failures++; $display("FAIL %s imm got=%h want=%h", name, bus.out_imm, imm_exp); end
        checks++; if (bus.out_illegal !== ill_exp) begin failures++; $display("FAIL %s illegal got=%b want=%b", name, bus.out_illegal, ill_exp); end
        if (chk_regs) begin
            checks++; if ({bus.out_rd, bus.out_rs1, bus.out_rs2} !== {rd_exp, rs1_exp, rs2_exp}) begin
                failures++; $display("FAIL %s regs got=%0d,%0d,%0d want=%0d,%0d,%0d", name,
                                     bus.out_rd, bus.out_rs1, bus.out_rs2, rd_exp, rs1_exp, rs2_exp);
            end
        end
        step();
        if (ill_exp) exp_cnt++;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s drained got=%b want=0", name, bus.out_valid); end
        checks++; if (bus.illegal_cnt !== exp_cnt[15:0]) begin failures++; $display("FAIL %s illegal_cnt got=%0d want=%0d", name, bus.illegal_cnt, exp_cnt); end
    endtask

    task automatic test_decode();
        decode_one("add",      32'h002081B3, 32'h100, 9'b100000000, 5'b00000, 32'h0,        1'b0, 1'b1, 5'd3, 5'd1, 5'd2);
        decode_one("addi_m1",  32'hFFF00093, 32'h104, 9'b010000000, 5'b00000, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd1, 5'd0, 5'd31);
        decode_one("lui",      32'h123452B7, 32'h108, 9'b001000000, 5'b01010, 32'h12345000, 1'b0, 1'b1, 5'd5, 5'd8, 5'd3);
        decode_one("auipc",    32'h00001517, 32'h10C, 9'b000100000, 5'b00000, 32'h00001000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        decode_one("sw",       32'h0020A423, 32'h110, 9'b000001000, 5'b00000, 32'h00000008, 1'b0, 1'b1, 5'd8, 5'd1, 5'd2);
        decode_one("beq_m4",   32'hFE208EE3, 32'h114, 9'b000000100, 5'b01000, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        decode_one("jal_p8",   32'h008000EF, 32'h118, 9'b000000010, 5'b00000, 32'h00000008, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        decode_one("sra",      32'h4020D1B3, 32'h11C, 9'b100000000, 5'b01001, 32'h0,        1'b0, 1'b1, 5'd3, 5'd1, 5'd2);
        decode_one("bad_f7",   32'h402091B3, 32'h120, 9'b000000000, 5'b00000, 32'h0,        1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        decode_one("bad_br",   32'h0020A063, 32'h124, 9'b000000000, 5'b00000, 32'h0,        1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_mext();
`ifdef DECODE_MEXT_EN
        decode_one("mul",      32'h022081B3, 32'h140, 9'b100000000, 5'b10000, 32'h0,        1'b0, 1'b1, 5'd3, 5'd1, 5'd2);
`else
        decode_one("mul",      32'h022081B3, 32'h140, 9'b000000000, 5'b00000, 32'h0,        1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
`endif
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h002081B3;
        bus.in_pc     = 32'h200;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b want=1", bus.in_ready); end
        bus.in_inst = 32'h123452B7;
        bus.in_pc   = 32'h204;
        step();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready2 got=%b want=0", bus.in_ready); end
        bus.in_inst = 32'hFFF00093;
        bus.in_pc   = 32'h208;
        step();
        step();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b want=0", bus.in_ready); end
        checks++; if (bus.out_pc !== 32'h200 || bus.out_is_r !== 1'b1) begin
            failures++; $display("FAIL b2b_stall got pc=%h is_r=%b want pc=200 is_r=1", bus.out_pc, bus.out_is_r);
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_is_lui !== 1'b1) begin
            failures++; $display("FAIL b2b_second got v=%b pc=%h lui=%b want v=1 pc=204 lui=1", bus.out_valid, bus.out_pc, bus.out_is_lui);
        end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_reopen got=%b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h208 || bus.out_is_i !== 1'b1) begin
            failures++; $display("FAIL b2b_third got v=%b pc=%h is_i=%b want v=1 pc=208 is_i=1", bus.out_valid, bus.out_pc, bus.out_is_i);
        end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0000007F;
        bus.in_pc     = 32'h300;
        step();
        bus.in_inst = 32'hFFF00093;
        bus.in_pc   = 32'h304;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_held got v=%b ill=%b rdy=%b want 1 1 0", bus.out_valid, bus.out_illegal, bus.in_ready);
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_empty got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.illegal_cnt !== exp_cnt[15:0]) begin failures++; $display("FAIL flush_cnt got=%0d want=%0d", bus.illegal_cnt, exp_cnt); end
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h002081B3;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop_accept got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0000007F;
        bus.in_pc     = 32'h400;
        step();
        bus.in_inst = 32'h002081B3;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0 || bus.illegal_cnt === 16'd0) begin
            failures++; $display("FAIL rstmid_pre got rdy=%b cnt=%0d want rdy=0 cnt nonzero", bus.in_ready, bus.illegal_cnt);
        end
        rst       = 1'b1;
        bus.flush = 1'b1;
        step();
        rst       = 1'b0;
        bus.flush = 1'b0;
        exp_cnt   = 0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_state got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.illegal_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d want=0", bus.illegal_cnt); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_decode();
        test_mext();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
